// File: rtl/boot_loader_ctrl_pkg.sv
// Shared definitions for the boot loader: header opcodes, FSM state
// encoding and helpers that pull the opcode and start address out of a
// header word.
package boot_pkg;

  localparam logic [1:0] OP_IMEM_WR = 2'b00;
  localparam logic [1:0] OP_DMEM_WR = 2'b01;
  localparam logic [1:0] OP_GO      = 2'b10;
  localparam logic [1:0] OP_RSVD    = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    DATA    = 3'd2,
    CSUM    = 3'd3,
    RELEASE = 3'd4,
    RUN     = 3'd5,
    ERROR   = 3'd6
  } boot_state_t;

  // Widest header the helpers can handle; callers zero-extend into it.
  localparam int HDR_MAX_W = 64;

  // Opcode lives in the top two bits of a data_w-bit header.
  function automatic logic [1:0] hdr_opcode(input logic [HDR_MAX_W-1:0] hdr,
                                            input int data_w);
    logic [HDR_MAX_W-1:0] sh;
    sh = hdr >> (data_w - 2);
    return sh[1:0];
  endfunction

  // Start address is the low addr_w bits; everything else is ignored.
  function automatic logic [HDR_MAX_W-1:0] hdr_addr(input logic [HDR_MAX_W-1:0] hdr,
                                                    input int addr_w);
    logic [HDR_MAX_W-1:0] mask;
    mask = ~({HDR_MAX_W{1'b1}} << addr_w);
    return hdr & mask;
  endfunction

endpackage

// File: rtl/boot_loader_ctrl_if.sv
// Host word stream (valid/ready) carrying boot headers and payload.
// The host drives through the master modport, the loader through slave.
interface boot_loader_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/boot_loader_ctrl_mem_mux.sv
// Port selector for one memory: boot write registers while loading,
// combinational pass-through of the CPU request once the CPU runs.
module boot_mem_mux #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              run_i,
  input  logic [ADDR_W-1:0] boot_addr_i,
  input  logic              boot_we_i,
  input  logic [DATA_W-1:0] boot_din_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic              cpu_we_i,
  input  logic [DATA_W-1:0] cpu_din_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_din_o
);

  // CPU write enables are dropped until run_i, since the CPU is in reset.
  always_comb begin
    mem_addr_o = run_i ? cpu_addr_i : boot_addr_i;
    mem_we_o   = run_i ? cpu_we_i   : boot_we_i;
    mem_din_o  = run_i ? cpu_din_i  : boot_din_i;
  end

endmodule

// File: rtl/boot_loader_ctrl.sv
// Boot loader: consumes header/length/payload words from a host stream,
// writes them into instruction ROM or data RAM, then releases CPU reset
// RELEASE_CYCLES clocks after a GO header.
// Optional build macro BOOT_CHECKSUM_EN adds a trailing checksum word
// after every payload (sum of header+length+payload+checksum must be 0).
module boot_loader_ctrl
  import boot_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 16,
  parameter int RELEASE_CYCLES = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  boot_loader_ctrl_if.slave  s,
  output logic               cpu_reset,
  output logic               boot_busy,
  output logic               boot_error,
  input  logic [ADDR_W-1:0]  cpu_imem_addr,
  input  logic               cpu_imem_we,
  input  logic [DATA_W-1:0]  cpu_imem_din,
  input  logic [ADDR_W-1:0]  cpu_dmem_addr,
  input  logic               cpu_dmem_we,
  input  logic [DATA_W-1:0]  cpu_dmem_din,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_we,
  output logic [DATA_W-1:0]  imem_din,
  output logic [ADDR_W-1:0]  dmem_addr,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_din
);

  generate
    if (DATA_W < ADDR_W + 2) begin : g_width_check
      $error("boot_loader_ctrl: DATA_W must be >= ADDR_W+2");
    end
    if (RELEASE_CYCLES < 1) begin : g_release_check
      $error("boot_loader_ctrl: RELEASE_CYCLES must be >= 1");
    end
  endgenerate

  localparam int REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_t PAYLOAD_END = CSUM;
`else
  localparam boot_state_t PAYLOAD_END = IDLE;
`endif

  boot_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;       // next write address
  logic              tgt_dmem_q, tgt_dmem_d; // 0: instruction ROM, 1: data RAM
  logic [DATA_W-1:0] remain_q, remain_d;   // payload words still expected
  logic [REL_W-1:0]  rel_q, rel_d;         // clocks spent in RELEASE
  logic              bw_imem_we_q, bw_imem_we_d;
  logic              bw_dmem_we_q, bw_dmem_we_d;
  logic [ADDR_W-1:0] bw_addr_q, bw_addr_d;
  logic [DATA_W-1:0] bw_din_q, bw_din_d;
`ifdef BOOT_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [DATA_W-1:0] sum_final;
`endif

  logic              accept;
  logic [1:0]        hdr_op;
  logic [ADDR_W-1:0] hdr_start;
  logic              running;

  assign s.s_ready = (state_q == IDLE) || (state_q == LEN) ||
                     (state_q == DATA) || (state_q == CSUM);
  assign accept    = s.s_valid && s.s_ready;
  assign hdr_op    = hdr_opcode(HDR_MAX_W'(s.s_data), DATA_W);
  assign hdr_start = ADDR_W'(hdr_addr(HDR_MAX_W'(s.s_data), ADDR_W));
`ifdef BOOT_CHECKSUM_EN
  assign sum_final = sum_q + s.s_data;
`endif

  assign running    = (state_q == RUN);
  assign cpu_reset  = !running;
  assign boot_busy  = !running;
  assign boot_error = (state_q == ERROR);

  // Next-state: header decode, payload sequencing and release countdown.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    tgt_dmem_d   = tgt_dmem_q;
    remain_d     = remain_q;
    rel_d        = rel_q;
    bw_imem_we_d = 1'b0;
    bw_dmem_we_d = 1'b0;
    bw_addr_d    = bw_addr_q;
    bw_din_d     = bw_din_q;
`ifdef BOOT_CHECKSUM_EN
    sum_d        = sum_q;
`endif
    case (state_q)
      IDLE: if (accept) begin
`ifdef BOOT_CHECKSUM_EN
        sum_d = s.s_data;
`endif
        case (hdr_op)
          OP_IMEM_WR: begin tgt_dmem_d = 1'b0; addr_d = hdr_start; state_d = LEN; end
          OP_DMEM_WR: begin tgt_dmem_d = 1'b1; addr_d = hdr_start; state_d = LEN; end
          OP_GO:      begin rel_d = '0; state_d = RELEASE; end
          default:    state_d = ERROR;
        endcase
      end
      LEN: if (accept) begin
        remain_d = s.s_data;
        state_d  = (s.s_data == '0) ? PAYLOAD_END : DATA;
`ifdef BOOT_CHECKSUM_EN
        sum_d    = sum_q + s.s_data;
`endif
      end
      DATA: if (accept) begin
        bw_imem_we_d = !tgt_dmem_q;
        bw_dmem_we_d = tgt_dmem_q;
        bw_addr_d    = addr_q;
        bw_din_d     = s.s_data;
        addr_d       = addr_q + ADDR_W'(1);
        remain_d     = remain_q - DATA_W'(1);
        if (remain_q == DATA_W'(1)) state_d = PAYLOAD_END;
`ifdef BOOT_CHECKSUM_EN
        sum_d        = sum_q + s.s_data;
`endif
      end
`ifdef BOOT_CHECKSUM_EN
      CSUM: if (accept) begin
        state_d = (sum_final == '0) ? IDLE : ERROR;
      end
`endif
      RELEASE: begin
        if (rel_q == REL_W'(RELEASE_CYCLES - 1)) state_d = RUN;
        else rel_d = rel_q + REL_W'(1);
      end
      RUN:     state_d = RUN;
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase
  end

  // State and boot write registers; reset aborts any load in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      tgt_dmem_q   <= 1'b0;
      remain_q     <= '0;
      rel_q        <= '0;
      bw_imem_we_q <= 1'b0;
      bw_dmem_we_q <= 1'b0;
      bw_addr_q    <= '0;
      bw_din_q     <= '0;
`ifdef BOOT_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      tgt_dmem_q   <= tgt_dmem_d;
      remain_q     <= remain_d;
      rel_q        <= rel_d;
      bw_imem_we_q <= bw_imem_we_d;
      bw_dmem_we_q <= bw_dmem_we_d;
      bw_addr_q    <= bw_addr_d;
      bw_din_q     <= bw_din_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  boot_mem_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_imem_mux (
    .run_i       (running),
    .boot_addr_i (bw_addr_q),
    .boot_we_i   (bw_imem_we_q),
    .boot_din_i  (bw_din_q),
    .cpu_addr_i  (cpu_imem_addr),
    .cpu_we_i    (cpu_imem_we),
    .cpu_din_i   (cpu_imem_din),
    .mem_addr_o  (imem_addr),
    .mem_we_o    (imem_we),
    .mem_din_o   (imem_din)
  );

  boot_mem_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dmem_mux (
    .run_i       (running),
    .boot_addr_i (bw_addr_q),
    .boot_we_i   (bw_dmem_we_q),
    .boot_din_i  (bw_din_q),
    .cpu_addr_i  (cpu_dmem_addr),
    .cpu_we_i    (cpu_dmem_we),
    .cpu_din_i   (cpu_dmem_din),
    .mem_addr_o  (dmem_addr),
    .mem_we_o    (dmem_we),
    .mem_din_o   (dmem_din)
  );

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Scoreboard bench for boot_loader_ctrl: stimulus pushes expected memory
// writes, a negedge monitor pops and compares every boot write it sees.
module tb_boot_loader_ctrl;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  boot_loader_ctrl_if #(.DATA_W(DATA_W)) s_if ();

  logic              cpu_reset, boot_busy, boot_error;
  logic [ADDR_W-1:0] cpu_imem_addr, cpu_dmem_addr, imem_addr, dmem_addr;
  logic              cpu_imem_we, cpu_dmem_we, imem_we, dmem_we;
  logic [DATA_W-1:0] cpu_imem_din, cpu_dmem_din, imem_din, dmem_din;

  boot_loader_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RELEASE_CYCLES(3)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .s             (s_if),
    .cpu_reset     (cpu_reset),
    .boot_busy     (boot_busy),
    .boot_error    (boot_error),
    .cpu_imem_addr (cpu_imem_addr),
    .cpu_imem_we   (cpu_imem_we),
    .cpu_imem_din  (cpu_imem_din),
    .cpu_dmem_addr (cpu_dmem_addr),
    .cpu_dmem_we   (cpu_dmem_we),
    .cpu_dmem_din  (cpu_dmem_din),
    .imem_addr     (imem_addr),
    .imem_we       (imem_we),
    .imem_din      (imem_din),
    .dmem_addr     (dmem_addr),
    .dmem_we       (dmem_we),
    .dmem_din      (dmem_din)
  );

  typedef struct packed {
    logic        dmem;
    logic [7:0]  addr;
    logic [15:0] din;
  } wr_t;

  wr_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every boot-phase write must match the head of the scoreboard.
  always @(negedge clock) begin : monitor
    wr_t got;
    wr_t e;
    if (reset_n && boot_busy && (imem_we || dmem_we)) begin
      got.dmem = dmem_we;
      got.addr = dmem_we ? dmem_addr : imem_addr;
      got.din  = dmem_we ? dmem_din : imem_din;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got dmem=%0d addr=0x%0h din=0x%0h, none expected",
                 got.dmem, got.addr, got.din);
      end else begin
        e = exp_q.pop_front();
        check("write", 32'(got), 32'(e));
        check("write_excl", 32'(imem_we & dmem_we), 32'd0);
      end
    end
  end

  // Present one word and hold it until the loader accepts it (bounded).
  task automatic send(input logic [15:0] w);
    int n;
    n = 0;
    s_if.s_valid = 1'b1;
    s_if.s_data  = w;
    while (!s_if.s_ready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (!s_if.s_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: word 0x%0h never accepted, required acceptance", w);
    end else begin
      @(posedge clock); #1;
    end
  endtask

  // Header + length + payload (base + i*step); stop_after >= 0 truncates.
  task automatic send_block(input logic [15:0] hdr, input int len,
                            input logic [15:0] base, input logic [15:0] step,
                            input bit gaps, input int stop_after);
    logic [15:0] sum;
    logic [15:0] w;
    logic [7:0]  a;
    sum = hdr;
    a   = hdr[7:0];
    send(hdr);
    send(16'(len));
    sum = sum + 16'(len);
    for (int i = 0; i < len; i++) begin
      if (stop_after >= 0 && i == stop_after) begin
        s_if.s_valid = 1'b0;
        return;
      end
      w = base + 16'(i) * step;
      exp_q.push_back('{dmem: hdr[14], addr: a, din: w});
      send(w);
      sum = sum + w;
      a   = a + 8'd1;
      if (gaps) begin
        s_if.s_valid = 1'b0;
        @(posedge clock); #1;
      end
    end
`ifdef BOOT_CHECKSUM_EN
    send(16'h0000 - sum);
`endif
    s_if.s_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s_if.s_valid  = 1'b0;
    s_if.s_data   = '0;
    // CPU requests are driven with writes during boot: they must be ignored.
    cpu_imem_we   = 1'b1; cpu_imem_addr = 8'h77; cpu_imem_din = 16'hDEAD;
    cpu_dmem_we   = 1'b1; cpu_dmem_addr = 8'h66; cpu_dmem_din = 16'hBEEF;

    // Reset state
    #12;
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_boot_busy", 32'(boot_busy), 32'd1);
    check("rst_boot_error", 32'(boot_error), 32'd0);
    check("rst_s_ready", 32'(s_if.s_ready), 32'd1);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_dmem_we", 32'(dmem_we), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_dmem_din", 32'(dmem_din), 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // 5 words of 0x1121 into IMEM from 0x00, back-to-back
    send_block(16'h0000, 5, 16'h1121, 16'h0000, 1'b0, -1);
    // DMEM wrap: 0xFE, 0xFF, 0x00
    send_block(16'h40FE, 3, 16'hAAAA, 16'h1111, 1'b0, -1);
    // valid toggling during DATA: exactly 3 writes
    send_block(16'h0020, 3, 16'h0101, 16'h0101, 1'b1, -1);
    // zero-length payload: no writes, back in IDLE
    send_block(16'h4050, 0, 16'h0000, 16'h0000, 1'b0, -1);
    repeat (3) @(posedge clock);
    #1;
    check("zero_len_s_ready", 32'(s_if.s_ready), 32'd1);
    check("zero_len_error", 32'(boot_error), 32'd0);
    check("boot_queue_empty", 32'(exp_q.size()), 32'd0);

    // Abort after 2 of 4 words
    send_block(16'h0030, 4, 16'h5000, 16'h0001, 1'b0, 2);
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check("abort_cpu_reset", 32'(cpu_reset), 32'd1);
    check("abort_imem_we", 32'(imem_we), 32'd0);
    check("abort_s_ready", 32'(s_if.s_ready), 32'd1);
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    check("abort_no_more_writes", 32'(exp_q.size()), 32'd0);

`ifdef BOOT_CHECKSUM_EN
    // Good checksum returns to IDLE
    exp_q.push_back('{dmem: 1'b0, addr: 8'h00, din: 16'h0010});
    send(16'h0000); send(16'h0001); send(16'h0010); send(16'hFFEF);
    s_if.s_valid = 1'b0;
    @(posedge clock); #1;
    check("csum_ok_error", 32'(boot_error), 32'd0);
    check("csum_ok_s_ready", 32'(s_if.s_ready), 32'd1);
    // Bad checksum goes to ERROR
    exp_q.push_back('{dmem: 1'b0, addr: 8'h00, din: 16'h0010});
    send(16'h0000); send(16'h0001); send(16'h0010); send(16'hFFEE);
    s_if.s_valid = 1'b0;
    @(posedge clock); #1;
    check("csum_bad_error", 32'(boot_error), 32'd1);
    check("csum_bad_s_ready", 32'(s_if.s_ready), 32'd0);
    pulse_reset();
`endif

    // GO: accepted at edge T, cpu_reset falls at T+3
    send(16'h8000);
    s_if.s_valid = 1'b0;
    check("go_s_ready", 32'(s_if.s_ready), 32'd0);
    check("go_cpu_reset_t0", 32'(cpu_reset), 32'd1);
    @(posedge clock); #1;
    check("go_cpu_reset_t1", 32'(cpu_reset), 32'd1);
    @(posedge clock); #1;
    check("go_cpu_reset_t2", 32'(cpu_reset), 32'd1);
    check("go_busy_t2", 32'(boot_busy), 32'd1);
    @(posedge clock); #1;
    check("go_cpu_reset_t3", 32'(cpu_reset), 32'd0);
    check("go_busy_t3", 32'(boot_busy), 32'd0);
    check("run_s_ready", 32'(s_if.s_ready), 32'd0);
    cpu_dmem_we = 1'b1; cpu_dmem_addr = 8'h10; cpu_dmem_din = 16'h1234;
    cpu_imem_we = 1'b0; cpu_imem_addr = 8'h42; cpu_imem_din = 16'h0000;
    #1;
    check("run_dmem_we", 32'(dmem_we), 32'd1);
    check("run_dmem_addr", 32'(dmem_addr), 32'h10);
    check("run_dmem_din", 32'(dmem_din), 32'h1234);
    check("run_imem_addr", 32'(imem_addr), 32'h42);
    check("run_imem_we", 32'(imem_we), 32'd0);
    cpu_dmem_we = 1'b0;

    // Reserved opcode -> ERROR; later GO ignored
    pulse_reset();
    send(16'hC000);
    s_if.s_valid = 1'b0;
    check("rsvd_error", 32'(boot_error), 32'd1);
    check("rsvd_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rsvd_s_ready", 32'(s_if.s_ready), 32'd0);
    s_if.s_valid = 1'b1;
    s_if.s_data  = 16'h8000;
    repeat (6) @(posedge clock);
    #1;
    s_if.s_valid = 1'b0;
    check("rsvd_go_ignored_reset", 32'(cpu_reset), 32'd1);
    check("rsvd_go_ignored_error", 32'(boot_error), 32'd1);
    check("rsvd_go_ignored_busy", 32'(boot_busy), 32'd1);

    repeat (2) @(posedge clock);
    #1;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
